// File: rtl/spi_slave_rx_if.sv
// Bundles the SPI pins and the receiver's parallel outputs.
// The transmitter side uses the master modport and the receiver uses the slave modport.
interface spi_slave_rx_if #(
  parameter int FRAME_BITS = 18
);
  logic                  sclk;
  logic                  mosi;
  logic                  cs_n;
  logic [FRAME_BITS-1:0] data_out;
  logic                  data_valid;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output sclk,
    output mosi,
    output cs_n,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  sclk,
    input  mosi,
    input  cs_n,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// Mode-0, MSB-first SPI frame receiver that oversamples SCLK/MOSI/CS_N on clk_sys.
// Emits each full frame with a one-cycle valid strobe and flags frames cut short.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   WAIT_CS | after reset or a full frame; ignore SCLK until CS_N is high
//   IDLE    | CS_N high, bit counter cleared, waiting for CS_N low
//   SHIFT   | frame in progress, shift MOSI on each synchronized SCLK rise
module spi_slave_rx #(
  parameter int FRAME_BITS = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave_rx_if.slave bus
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    WAIT_CS = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sclk_s1_d, sclk_s2_d, sclk_s3_d;
  logic mosi_s1_q, mosi_s2_q;
  logic mosi_s1_d, mosi_s2_d;
  logic cs_n_s1_q, cs_n_s2_q, cs_n_s3_q;
  logic cs_n_s1_d, cs_n_s2_d, cs_n_s3_d;

  state_t                state_q,      state_d;
  logic [FRAME_BITS-1:0] shift_reg_q,  shift_reg_d;
  logic [FRAME_BITS-1:0] data_out_q,   data_out_d;
  logic [CW-1:0]         bit_cnt_q,    bit_cnt_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q,  frame_err_d;
  logic                  busy_q,       busy_d;

  logic                  rise;
  logic                  cs_low;
  logic                  cs_rise;
  logic                  cs_abort;
  logic [FRAME_BITS-1:0] shifted;

  always_comb begin
    sclk_s1_d = bus.sclk;
    sclk_s2_d = sclk_s1_q;
    sclk_s3_d = sclk_s2_q;
    mosi_s1_d = bus.mosi;
    mosi_s2_d = mosi_s1_q;
    cs_n_s1_d = bus.cs_n;
    cs_n_s2_d = cs_n_s1_q;
    cs_n_s3_d = cs_n_s2_q;
  end

  assign rise     = sclk_s2_q & ~sclk_s3_q;
  assign cs_low   = ~cs_n_s2_q;
  assign cs_rise  = cs_n_s2_q & ~cs_n_s3_q;
  assign cs_abort = cs_n_s2_q | cs_rise;
  assign shifted  = {shift_reg_q[FRAME_BITS-2:0], mosi_s2_q};

  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    data_out_d   = data_out_q;
    bit_cnt_d    = bit_cnt_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      WAIT_CS: begin
        if (cs_n_s2_q) state_d = IDLE;
      end
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_low) state_d = SHIFT;
      end
      SHIFT: begin
        // CS_N wins over a coincident SCLK rise, so a late last bit still aborts.
        if (cs_abort) begin
          if (bit_cnt_q != '0) frame_err_d = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          shift_reg_d = shifted;
          bit_cnt_d   = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            data_out_d   = shifted;
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            state_d      = WAIT_CS;
          end
        end
      end
      default: state_d = WAIT_CS;
    endcase

    busy_d = (state_d == SHIFT);
  end

  // cs_n synchronizers reset low so a genuine CS_N high is required before the first frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s1_q    <= 1'b0;
      sclk_s2_q    <= 1'b0;
      sclk_s3_q    <= 1'b0;
      mosi_s1_q    <= 1'b0;
      mosi_s2_q    <= 1'b0;
      cs_n_s1_q    <= 1'b0;
      cs_n_s2_q    <= 1'b0;
      cs_n_s3_q    <= 1'b0;
      state_q      <= WAIT_CS;
      shift_reg_q  <= '0;
      data_out_q   <= '0;
      bit_cnt_q    <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sclk_s1_q    <= sclk_s1_d;
      sclk_s2_q    <= sclk_s2_d;
      sclk_s3_q    <= sclk_s3_d;
      mosi_s1_q    <= mosi_s1_d;
      mosi_s2_q    <= mosi_s2_d;
      cs_n_s1_q    <= cs_n_s1_d;
      cs_n_s2_q    <= cs_n_s2_d;
      cs_n_s3_q    <= cs_n_s3_d;
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      data_out_q   <= data_out_d;
      bit_cnt_q    <= bit_cnt_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: stimulus queues expected strobes,
// a monitor pops and checks them whenever data_valid or frame_err fires.
module tb_spi_slave_rx;

  localparam int FB = 18;
  localparam int HP = 32;

  typedef struct {
    bit            is_err;
    logic [FB-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];
  logic [FB-1:0] last_good;

  spi_slave_rx_if #(.FRAME_BITS(FB)) bus ();

  spi_slave_rx #(.FRAME_BITS(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit is_err, input logic [FB-1:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic cs_low_t();
    bus.cs_n = 1'b0;
    wait_clk(HP);
  endtask

  task automatic cs_high_t(input int gap);
    bus.cs_n = 1'b1;
    wait_clk(gap);
  endtask

  // MOSI changes with SCLK low; lat_chk times data_valid against the final rise.
  task automatic send_bits(input logic [31:0] v, input int n, input bit lat_chk);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = v[i];
      wait_clk(HP);
      bus.sclk = 1'b1;
      if (lat_chk && i == 0) begin
        wait_clk(2);
        chk("latency_early", 32'(bus.data_valid), 32'd0);
        wait_clk(1);
        chk("latency_hit", 32'(bus.data_valid), 32'd1);
        wait_clk(HP - 3);
      end else begin
        wait_clk(HP);
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic good_frame(input logic [FB-1:0] v);
    push(1'b0, v);
    cs_low_t();
    send_bits(32'(v), FB, 1'b0);
    cs_high_t(4);
    last_good = v;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.data_valid && bus.frame_err)
        chk("strobe_overlap", 32'd1, 32'd0);
      if (bus.data_valid || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, bus.frame_err, bus.data_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(bus.frame_err), 32'(e.is_err));
          chk("data_out", 32'(bus.data_out), 32'(e.data));
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total     = 0;
    bad       = 0;
    last_good = '0;
    rst_n     = 1'b0;
    bus.cs_n  = 1'b1;
    bus.sclk  = 1'b0;
    bus.mosi  = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(1);
    chk("rst_data_out",   32'(bus.data_out),   32'd0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_frame_err",  32'(bus.frame_err),  32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    wait_clk(4);

    // nominal frame with latency and busy checks
    push(1'b0, 18'h2A5C3);
    cs_low_t();
    chk("busy_in_frame", 32'(bus.busy), 32'd1);
    send_bits(32'h2A5C3, FB, 1'b1);
    chk("busy_after_frame", 32'(bus.busy), 32'd0);
    cs_high_t(4);
    last_good = 18'h2A5C3;

    // back-to-back frames with a 4-clk CS_N gap
    good_frame(18'h3FFFF);
    good_frame(18'h00001);

    // short frame after a good one
    good_frame(18'h12345);
    push(1'b1, 18'h12345);
    cs_low_t();
    send_bits(32'h2B5, 10, 1'b0);
    bus.cs_n = 1'b1;
    wait_clk(6);
    chk("short_busy", 32'(bus.busy), 32'd0);
    chk("short_data_hold", 32'(bus.data_out), 32'h12345);

    // overlong frame: two trailing rises ignored
    push(1'b0, 18'h15555);
    cs_low_t();
    send_bits({12'd0, 18'h15555, 2'b10}, FB + 2, 1'b0);
    cs_high_t(4);
    last_good = 18'h15555;
    chk("overlong_data", 32'(bus.data_out), 32'h15555);

    // reset seven bits into a frame, then finish that frame with CS_N still low
    cs_low_t();
    send_bits(32'h5A, 7, 1'b0);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    last_good = '0;
    wait_clk(1);
    chk("midrst_data_out", 32'(bus.data_out), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    send_bits(32'h7C3, 11, 1'b0);
    wait_clk(4);
    chk("midrst_still_idle", 32'(bus.busy), 32'd0);
    cs_high_t(4);
    good_frame(18'h0ABCD);

    // 18th SCLK rise coincides with CS_N rise: abort wins
    push(1'b1, 18'h0ABCD);
    cs_low_t();
    send_bits(32'h1FFFF, 17, 1'b0);
    bus.mosi = 1'b1;
    wait_clk(HP);
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    wait_clk(HP);
    bus.sclk = 1'b0;
    chk("simul_busy", 32'(bus.busy), 32'd0);
    chk("simul_data_hold", 32'(bus.data_out), 32'h0ABCD);
    wait_clk(4);

    // block must be back in IDLE and accept a fresh frame
    good_frame(18'h1E0F1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clk(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
